// File: rtl/avmm_mc_pkg.sv
// rtl/avmm_mc_pkg.sv - shared types and helpers for the multi-channel SDRAM read wrapper
package avmm_mc_pkg;

  localparam int MC_ADDR_W = 32;
  localparam int MC_CNT_W  = 11;

  typedef enum logic [1:0] {IDLE, ARB, CMD, DATA} mc_state_e;

  typedef struct packed {
    logic [MC_ADDR_W-1:0] addr;
    logic [MC_CNT_W-1:0]  remaining;
    logic                 busy;
  } ch_req_t;

  function automatic int unsigned min_burst(input int unsigned remaining, input int unsigned max_burst);
    return (remaining < max_burst) ? remaining : max_burst;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant, search starts at ptr
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  always_comb begin
    int   c;
    logic found;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int k = 0; k < N; k++) begin
      c = (int'(ptr) + k) % N;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        idx      = IW'(c);
      end
    end
  end

endmodule

// File: rtl/avmm_sdram_mc_read_wrapper.sv
// rtl/avmm_sdram_mc_read_wrapper.sv - N-channel burst-splitting Avalon-MM read master
module avmm_sdram_mc_read_wrapper
  import avmm_mc_pkg::*;
#(
  parameter int SDRAM_W   = 128,
  parameter int N_CH      = 2,
  parameter int ADDR_W    = MC_ADDR_W,
  parameter int CNT_W     = MC_CNT_W,
  parameter int MAX_BURST = 16,
  parameter int BURST_W   = $clog2(MAX_BURST) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       read_start,
  input  logic [N_CH*ADDR_W-1:0] read_addr,
  input  logic [N_CH*CNT_W-1:0] read_cnt,
  output logic [N_CH-1:0]       read_busy,
  output logic [N_CH-1:0]       read_valid,
  output logic [SDRAM_W-1:0]    read_data,
  output logic [N_CH-1:0]       read_done,
  output logic [ADDR_W-1:0]     address,
  output logic                  read,
  output logic [BURST_W-1:0]    burstcount,
  input  logic                  waitrequest,
  input  logic [SDRAM_W-1:0]    readdata,
  input  logic                  readdatavalid
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(SDRAM_W / 8);

  mc_state_e           state_q, state_d;
  ch_req_t             ch_q [N_CH];
  logic [PTR_W-1:0]    ptr_q, g_q, arb_idx;
  logic [N_CH-1:0]     pending, arb_grant, g_oh_q, finish_mask;
  logic [BURST_W-1:0]  blen_q, beats_q;
  logic [N_CH-1:0]     valid_q, done_q;
  logic [SDRAM_W-1:0]  data_q;
  logic                beat, last_beat, ch_last;

  always_comb begin
    pending   = '0;
    read_busy = '0;
    for (int i = 0; i < N_CH; i++) begin
      pending[i]   = ch_q[i].busy && (ch_q[i].remaining != '0);
      read_busy[i] = ch_q[i].busy;
    end
  end

  rr_arbiter #(.N(N_CH), .IW(PTR_W)) u_arb (
    .req   (pending),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  assign beat        = (state_q == DATA) && readdatavalid;
  assign last_beat   = beat && (beats_q == BURST_W'(1));
  assign ch_last     = (ch_q[g_q].remaining == MC_CNT_W'(1));
  assign finish_mask = ch_last ? g_oh_q : '0;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (|pending) state_d = ARB;
      ARB:  state_d = CMD;
      CMD:  if (!waitrequest) state_d = DATA;
      DATA: if (last_beat) state_d = (|(pending & ~finish_mask)) ? ARB : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read       = (state_q == CMD);
    address    = read ? ch_q[g_q].addr : '0;
    burstcount = read ? blen_q : '0;
  end

  assign read_valid = valid_q;
  assign read_data  = data_q;
  assign read_done  = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      g_q     <= '0;
      g_oh_q  <= '0;
      blen_q  <= '0;
      beats_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      data_q  <= '0;
      for (int i = 0; i < N_CH; i++) ch_q[i] <= '0;
    end else begin
      valid_q <= '0;
      done_q  <= '0;
      // busy lingers one cycle after the final beat so done precedes the release
      for (int i = 0; i < N_CH; i++) begin
        if (!ch_q[i].busy) begin
          if (read_start[i]) begin
            ch_q[i].addr      <= read_addr[i*ADDR_W +: ADDR_W];
            ch_q[i].remaining <= read_cnt[i*CNT_W +: CNT_W];
            ch_q[i].busy      <= (read_cnt[i*CNT_W +: CNT_W] != '0);
            done_q[i]         <= (read_cnt[i*CNT_W +: CNT_W] == '0);
          end
        end else if (ch_q[i].remaining == '0) begin
          ch_q[i].busy <= 1'b0;
        end
      end
      if (state_q == ARB) begin
        g_q     <= arb_idx;
        g_oh_q  <= arb_grant;
        blen_q  <= BURST_W'(min_burst(int'(ch_q[arb_idx].remaining), MAX_BURST));
        beats_q <= BURST_W'(min_burst(int'(ch_q[arb_idx].remaining), MAX_BURST));
      end
      if (beat) begin
        valid_q                <= g_oh_q;
        data_q                 <= readdata;
        ch_q[g_q].remaining    <= ch_q[g_q].remaining - 1'b1;
        beats_q                <= beats_q - 1'b1;
        if (last_beat) begin
          ch_q[g_q].addr <= ch_q[g_q].addr + ADDR_W'(blen_q) * BEAT_BYTES;
          ptr_q          <= (g_q == PTR_W'(N_CH - 1)) ? '0 : g_q + 1'b1;
          if (ch_last) done_q[g_q] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_avmm_sdram_mc_read_wrapper.sv
// tb/tb_avmm_sdram_mc_read_wrapper.sv - scoreboard bench with an Avalon-MM memory model
module tb_avmm_sdram_mc_read_wrapper;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    read_start;
  logic [63:0]   read_addr;
  logic [21:0]   read_cnt;
  logic [1:0]    read_busy, read_valid, read_done;
  logic [127:0]  read_data;
  logic [31:0]   address;
  logic          read;
  logic [4:0]    burstcount;
  logic          waitrequest;
  logic [127:0]  readdata;
  logic          readdatavalid;

  avmm_sdram_mc_read_wrapper dut (
    .clk(clk), .rst(rst), .read_start(read_start), .read_addr(read_addr), .read_cnt(read_cnt),
    .read_busy(read_busy), .read_valid(read_valid), .read_data(read_data), .read_done(read_done),
    .address(address), .read(read), .burstcount(burstcount), .waitrequest(waitrequest),
    .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [127:0] exp_q0[$], exp_q1[$];
  logic [36:0]  exp_cmd[$];
  int exp_done[2];
  int seen[2];
  int accepts = 0, read_cycles = 0, stall_left = 0, beats_left = 0;
  logic [31:0] beat_addr = '0, snap_addr = '0;
  logic [4:0]  snap_len = '0;
  logic        snap_valid = 1'b0;

  function automatic logic [127:0] mem(input logic [31:0] a);
    return {a, ~a, a ^ 32'hA5A5_5A5A, a + 32'h1357_9BDF};
  endfunction

  task automatic fail(input string name, input logic [127:0] act, input logic [127:0] exp);
    failures++;
    $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) fail(name, act, exp);
  endtask

  // Memory model: stalls on request, returns a burst of address-derived beats after acceptance
  always @(negedge clk) begin
    if (read) read_cycles++;
    if (beats_left > 0) begin
      readdatavalid = 1'b1;
      readdata      = mem(beat_addr);
      beat_addr     = beat_addr + 32'd16;
      beats_left--;
    end else begin
      readdatavalid = 1'b0;
      readdata      = '0;
    end
    if (read && stall_left > 0) begin
      waitrequest = 1'b1;
      if (!snap_valid) begin
        snap_valid = 1'b1;
        snap_addr  = address;
        snap_len   = burstcount;
      end else begin
        check("cmd_stable", {address, burstcount}, {snap_addr, snap_len});
      end
      stall_left--;
    end else begin
      waitrequest = 1'b0;
      snap_valid  = 1'b0;
      if (read) begin
        accepts++;
        checks++;
        if (exp_cmd.size() == 0) fail("unexpected_cmd", {address, burstcount}, 0);
        else begin
          logic [36:0] e;
          e = exp_cmd.pop_front();
          if ({address, burstcount} !== e) fail("cmd", {address, burstcount}, e);
        end
        beat_addr  = address;
        beats_left = int'(burstcount);
      end
    end
  end

  task automatic chk_beat(input int ch);
    logic [127:0] e;
    int sz;
    sz = (ch == 0) ? exp_q0.size() : exp_q1.size();
    checks++;
    if (sz == 0) fail($sformatf("unexpected_beat_ch%0d", ch), read_data, 0);
    else begin
      e = (ch == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
      if (read_data !== e) fail($sformatf("beat_data_ch%0d", ch), read_data, e);
    end
    seen[ch]++;
  endtask

  always @(negedge clk) begin
    if (read_valid != 2'b00) begin
      checks++;
      if (!$onehot(read_valid)) fail("valid_onehot", read_valid, 0);
      else chk_beat(read_valid[1] ? 1 : 0);
    end
    for (int ch = 0; ch < 2; ch++) begin
      if (read_done[ch]) begin
        int sz;
        sz = (ch == 0) ? exp_q0.size() : exp_q1.size();
        checks++;
        if (exp_done[ch] == 0 || sz != 0) fail($sformatf("done_ch%0d", ch), sz, exp_done[ch]);
        else exp_done[ch]--;
      end
    end
  end

  task automatic expect_req(input int ch, input logic [31:0] a, input int n);
    for (int k = 0; k < n; k++) begin
      if (ch == 0) exp_q0.push_back(mem(a + 32'(16 * k)));
      else         exp_q1.push_back(mem(a + 32'(16 * k)));
    end
    exp_done[ch]++;
  endtask

  task automatic push_cmd(input logic [31:0] a, input int len);
    exp_cmd.push_back({a, 5'(len)});
  endtask

  task automatic issue(input logic [1:0] mask, input logic [31:0] a0, input int c0,
                       input logic [31:0] a1, input int c1);
    read_addr  = {a1, a0};
    read_cnt   = {11'(c1), 11'(c0)};
    read_start = mask;
    @(negedge clk); #1;
    read_start = 2'b00;
  endtask

  function automatic bit idle_now();
    return exp_q0.size() == 0 && exp_q1.size() == 0 && exp_cmd.size() == 0 &&
           exp_done[0] == 0 && exp_done[1] == 0 && read_busy == 2'b00 && beats_left == 0;
  endfunction

  task automatic wait_idle(input string name, input int max);
    int n = 0;
    while (n < max && !idle_now()) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (!idle_now()) fail({name, "_idle_timeout"}, exp_q0.size() + exp_q1.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, acc0, rc0, n;
    bit ok;
    rst = 1'b1; read_start = '0; read_addr = '0; read_cnt = '0;
    waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {read_busy, read_valid, read_done, read, burstcount, address}, 0);
    check("reset_data", read_data, 0);
    #1 rst = 1'b0;
    @(negedge clk); #1;

    // simultaneous starts, pointer at 0: ch0, ch1, ch0, ch1
    push_cmd(32'h3000_0000, 16); push_cmd(32'h4000_0000, 16);
    push_cmd(32'h3000_0100, 16); push_cmd(32'h4000_0100, 16);
    expect_req(0, 32'h3000_0000, 32);
    expect_req(1, 32'h4000_0000, 32);
    issue(2'b11, 32'h3000_0000, 32, 32'h4000_0000, 32);
    check("dual_busy", read_busy, 2'b11);
    wait_idle("dual", 600);

    // single short burst, done timing and busy release
    push_cmd(32'h2000_0000, 5);
    expect_req(0, 32'h2000_0000, 5);
    issue(2'b01, 32'h2000_0000, 5, 32'h0, 0);
    ok = 0; n = 0;
    while (n < 100 && !ok) begin
      @(negedge clk);
      if (read_done[0]) ok = 1;
      n++;
    end
    checks++;
    if (!ok) fail("t1_done_timeout", 0, 1);
    else begin
      check("t1_valid_with_done", read_valid, 2'b01);
      check("t1_busy_at_done", read_busy[0], 1'b1);
      @(negedge clk);
      check("t1_busy_after_done", read_busy[0], 1'b0);
    end
    #1;
    wait_idle("t1", 100);

    // 40 beats split 16/16/8
    push_cmd(32'h2000_0000, 16); push_cmd(32'h2000_0100, 16); push_cmd(32'h2000_0200, 8);
    expect_req(0, 32'h2000_0000, 40);
    issue(2'b01, 32'h2000_0000, 40, 32'h0, 0);
    wait_idle("split", 400);

    // command stalled by waitrequest for 7 cycles
    stall_left = 7;
    acc0 = accepts;
    push_cmd(32'h5000_0010, 3);
    expect_req(1, 32'h5000_0010, 3);
    issue(2'b10, 32'h0, 0, 32'h5000_0010, 3);
    wait_idle("stall", 100);
    check("stall_accepts", accepts - acc0, 1);
    check("stall_consumed", stall_left, 0);

    // zero-count request on ch1
    rc0 = read_cycles;
    exp_done[1]++;
    issue(2'b10, 32'h0, 0, 32'h5555_0000, 0);
    check("zero_done", read_done, 2'b10);
    check("zero_busy", read_busy, 2'b00);
    repeat (4) @(negedge clk);
    #1;
    check("zero_no_read", read_cycles - rc0, 0);

    // second start on a busy channel is ignored
    push_cmd(32'h2100_0000, 5);
    expect_req(0, 32'h2100_0000, 5);
    issue(2'b01, 32'h2100_0000, 5, 32'h0, 0);
    @(negedge clk); #1;
    check("ignore_busy", read_busy[0], 1'b1);
    issue(2'b01, 32'h2200_0000, 3, 32'h0, 0);
    wait_idle("ignore", 100);

    // reset in the middle of a burst with beats still returning
    push_cmd(32'h6000_0000, 16);
    expect_req(0, 32'h6000_0000, 16);
    s0 = seen[0];
    issue(2'b01, 32'h6000_0000, 16, 32'h0, 0);
    n = 0;
    while (n < 100 && seen[0] < s0 + 13) begin
      @(negedge clk); #1;
      n++;
    end
    check("rst_mid_reached", seen[0] - s0, 13);
    rst = 1'b1;
    exp_q0.delete();
    exp_done[0] = 0;
    @(negedge clk);
    check("rst_mid_ctrl", {read_busy, read_valid, read_done, read, burstcount, address}, 0);
    check("rst_mid_data", read_data, 0);
    #1 rst = 1'b0;
    s0 = seen[0];
    n = 0;
    while (n < 20 && beats_left > 0) begin
      @(negedge clk); #1;
      n++;
    end
    repeat (3) @(negedge clk);
    #1;
    check("rst_stray_ignored", seen[0] - s0, 0);
    push_cmd(32'h7000_0040, 4);
    expect_req(0, 32'h7000_0040, 4);
    issue(2'b01, 32'h7000_0040, 4, 32'h0, 0);
    wait_idle("post_rst", 100);
    check("post_rst_beats", seen[0] - s0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
